output_drain: RTL and testbench
===============================

# output_drain

Drains a finished output tile from the accumulation buffer's write-back bank and streams it off-chip over a valid/ready interface. It sits directly downstream of the accumulation buffer's read-only port (`ren_wb` / `radr_wb` / `rdata_wb`). It issues sequential reads and absorbs the bank's 1-cycle read latency and any output back-pressure in a 2-entry skid FIFO. `busy` tells the top-level controller when the bank may be switched.

## Interface
- `DATA_WIDTH`, 64, width of one accumulation-buffer word and of `out_data`.
- `BANK_ADDR_WIDTH`, 7, address width of one accumulation-buffer bank.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-high. `rst_n`=1 sampled at a rising edge resets the block.
- `start`  in  1  pulse that begins a drain; sampled only in IDLE.
- `num_words`  in  BANK_ADDR_WIDTH+1  words to drain (0..2^BANK_ADDR_WIDTH); sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `ren_wb`  out  1  read enable to the write-back bank.
- `radr_wb`  out  BANK_ADDR_WIDTH  read address.
- `rdata_wb`  in  DATA_WIDTH  read data, valid the cycle after `ren_wb`.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `out_data`  out  DATA_WIDTH  head of the skid FIFO.

## Operation
- **FSM states:** IDLE, DRAIN, FLUSH, DONE.
- **IDLE:**
  - `start`=1 and `num_words`>0 → DRAIN. Latch `num_words`; clear the issue counter `rd_cnt` and the address.
  - `start`=1 and `num_words`=0 → DONE. No reads are issued.
- **DRAIN:**
  - `ren_wb` = (`rd_cnt` < N) and (`fifo_count` + `inflight` − `pop`) < 2.
  - `pop` = `out_valid` & `out_ready`. `inflight` = `ren_wb` registered one cycle.
  - `radr_wb` = `rd_cnt`[BANK_ADDR_WIDTH-1:0]. `rd_cnt` increments on each read.
  - After the read that makes `rd_cnt` = N → FLUSH.
- **FLUSH:** when `inflight`=0 and the FIFO becomes empty after this cycle's pop → DONE.
- **DONE:** `done`=1 for exactly one cycle → IDLE.
- **Skid FIFO:**
  - 2 entries. A push occurs when `inflight`=1, capturing `rdata_wb`.
  - Push and pop in the same cycle is allowed; the count is unchanged.
  - The credit rule guarantees the FIFO never overflows.
  - `out_valid` = `fifo_count` > 0. `out_data` = head entry, held stable while `out_valid`=1 and `out_ready`=0.
- **Other rules:**
  - `start` outside IDLE is ignored.
  - `num_words` is used only when sampled; later changes have no effect.
  - Address wraps are impossible: N ≤ 2^BANK_ADDR_WIDTH, and the last address issued is N−1.
  - `out_ready` high while `out_valid`=0 has no effect.
- **Reset** (including mid-drain): state → IDLE; counters, `inflight` and FIFO pointers are cleared; any in-flight read is discarded.
  - Outputs after reset: `busy`=0, `done`=0, `ren_wb`=0, `radr_wb`=0, `out_valid`=0, `out_data`=0.

## Timing
- **Start:** `start` sampled at edge 0. DRAIN begins in cycle 1, where `ren_wb`=1 and `radr_wb`=0.
- **First word:** `rdata_wb` arrives in cycle 2 and is pushed at the end of cycle 2. `out_valid`=1 from cycle 3.
- **Latency:** `start` to first `out_valid` is 3 cycles.
- **Throughput:** with `out_ready` held at 1, one word per cycle. Reads occur in cycles 1..N, outputs in cycles 3..N+2, and `done` in cycle N+3.
- **Back-pressure:** `ren_wb` drops within one cycle of `out_ready` going low. At most 2 words are buffered. Output resumes the cycle `out_ready` returns, with no bubble.
- **Zero-length drain:** `num_words`=0 gives `done` in cycle 1 and `busy`=1 only in cycle 1.
- **Bank switching:** the controller must not assert `switch_banks` while `busy`=1. The cycle `done` is high is the earliest legal switch.

## Test plan
- **Full drain:**
  - Stimulus: bank preloaded with word[i]=i+0x100; `num_words`=128; `out_ready`=1.
  - Response: 128 in-order words 0x100..0x17F in cycles 3..130; `done` in cycle 131; `radr_wb` runs 0..127.
- **Back-pressure:**
  - Stimulus: `num_words`=8; `out_ready` toggles 1,0,0,1,…
  - Response: all 8 words delivered exactly once, in order; `out_data` stable while stalled; FIFO count never exceeds 2.
- **Zero length:**
  - Stimulus: `start` with `num_words`=0.
  - Response: no `ren_wb`; `done`=1 in cycle 1; `busy` high for one cycle.
- **Restart protection:**
  - Stimulus: second `start` with `num_words`=5 issued mid-drain of 10.
  - Response: exactly 10 words and a single `done`. A new `start` after `done` drains 5.
- **Reset mid-drain:**
  - Stimulus: `rst_n`=1 after 4 of 10 words are accepted.
  - Response: next cycle `busy`=0, `out_valid`=0, `ren_wb`=0. A following drain of 3 words returns addresses 0..2 correctly.
- **Stall at start:**
  - Stimulus: `out_ready`=0 from `start` until cycle 10, `num_words`=4.
  - Response: exactly 2 reads issued; output resumes at cycle 10 with words 0..3 on consecutive cycles.

Source files
------------

// File: rtl/output_drain.sv
// Drains one finished tile from the accumulation buffer write-back bank and
// streams it out over valid/ready, absorbing read latency in a 2-entry skid FIFO.
module output_drain #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BANK_ADDR_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BANK_ADDR_WIDTH:0]   num_words,
  output logic                       busy,
  output logic                       done,
  output logic                       ren_wb,
  output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
  input  logic [DATA_WIDTH-1:0]      rdata_wb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data
);

  localparam int unsigned CNT_W = BANK_ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      n_words;
  logic [CNT_W-1:0]      rd_cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic                  push;
  logic                  pop;
  logic [2:0]            occupancy;

  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  // Words already held or on their way, after this cycle's pop leaves.
  assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign radr_wb   = rd_cnt[BANK_ADDR_WIDTH-1:0];
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];

  // Next-state and credit-based read issue.
  always_comb begin
    state_nxt = state;
    ren_wb    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (num_words == '0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        ren_wb = (rd_cnt < n_words) && (occupancy < 3'd2);
        if (ren_wb && ((rd_cnt + CNT_W'(1)) == n_words)) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (!inflight && ((fifo_count - 2'(pop)) == 2'd0)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= S_IDLE;
      n_words  <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= ren_wb;
      if ((state == S_IDLE) && start) begin
        n_words <= num_words;
        rd_cnt  <= '0;
      end else if (ren_wb) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

  // Skid FIFO; the read credit above keeps it from ever overflowing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rdata_wb;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain.sv
// Bench for output_drain: bank model, directed drains and randomized
// back-pressure checked against a transaction-level reference model.
module tb_output_drain;

  localparam int unsigned DW     = 64;
  localparam int unsigned AW     = 7;
  localparam int unsigned NW     = AW + 1;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int          BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          out_ready;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic          ren_wb;
  logic          out_valid;
  logic [AW-1:0] radr_wb;
  logic [DW-1:0] rdata_wb;
  logic [DW-1:0] out_data;
  logic [DW-1:0] bank [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words still owed, reads still owed, active/done flags.
  logic [DW-1:0] exp_q [$];
  bit            m_active;
  bit            m_done_next;
  bit            m_post_rst;
  bit            m_prev_stall;
  logic [DW-1:0] m_prev_data;
  int            m_addr;
  int            m_reads_left;
  int            m_outstanding;
  int            m_acc;

  always #5 clk = ~clk;

  // Write-back bank: one-cycle read latency.
  always @(posedge clk) begin
    if (ren_wb === 1'b1) rdata_wb <= bank[radr_wb];
  end

  output_drain #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .ren_wb    (ren_wb),
    .radr_wb   (radr_wb),
    .rdata_wb  (rdata_wb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    bit was_active;
    bit acc;
    bit dn;
    if (rst_n === 1'b1) begin
      m_active      = 1'b0;
      m_done_next   = 1'b0;
      m_post_rst    = 1'b1;
      m_prev_stall  = 1'b0;
      m_addr        = 0;
      m_reads_left  = 0;
      m_outstanding = 0;
      exp_q.delete();
      return;
    end
    was_active = m_active;
    chk("busy", 64'(busy), 64'(m_active));
    chk("done", 64'(done), 64'(m_done_next));
    if (m_post_rst) begin
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_ren",   64'(ren_wb),    64'(0));
      chk("rst_radr",  64'(radr_wb),   64'(0));
      chk("rst_data",  out_data,       64'(0));
    end
    if (m_prev_stall) chk("hold_data", out_data, m_prev_data);
    chk("buffer_bound", 64'(m_outstanding <= 2), 64'(1));
    if (ren_wb === 1'b1) begin
      chk("read_allowed", 64'(m_reads_left > 0), 64'(1));
      chk("read_addr", 64'(radr_wb), 64'(m_addr));
      m_addr++;
      m_reads_left--;
      m_outstanding++;
    end
    acc = (out_valid === 1'b1) && (out_ready === 1'b1);
    dn  = 1'b0;
    if (acc) begin
      chk("word_pending", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
      m_outstanding--;
      m_acc++;
      if (exp_q.size() == 0 && m_reads_left <= 0) dn = 1'b1;
    end
    if (m_done_next) m_active = 1'b0;
    if (start === 1'b1 && !was_active) begin
      m_active     = 1'b1;
      m_addr       = 0;
      m_reads_left = int'(num_words);
      exp_q.delete();
      for (int i = 0; i < int'(num_words); i++) exp_q.push_back(bank[i]);
      if (num_words == '0) dn = 1'b1;
    end
    m_done_next  = dn;
    m_post_rst   = 1'b0;
    m_prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    m_prev_data  = out_data;
  endtask

  // One clock: drive just after the edge, check at the falling edge.
  task automatic cyc(input logic rdy, input logic st, input logic [AW:0] nw, input logic rs);
    @(posedge clk);
    #1;
    out_ready = rdy;
    start     = st;
    num_words = nw;
    rst_n     = rs;
    @(negedge clk);
    observe();
  endtask

  function automatic logic rdy_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return logic'((c % 3) == 0);
      2:       return logic'($urandom_range(0, 1));
      default: return logic'(c >= 10);
    endcase
  endfunction

  // mode: 0 ready high, 1 toggle 1,0,0, 2 random, 3 stalled until cycle 10.
  task automatic run_drain(input int n, input int mode, input int restart_at, input int rst_after);
    int   acc0;
    int   reads_by_9;
    logic st;
    acc0       = m_acc;
    reads_by_9 = 0;
    cyc(rdy_for(mode, 0), 1'b1, NW'(n), 1'b0);
    for (int c = 1; c < BUDGET; c++) begin
      st = logic'(c == restart_at);
      cyc(rdy_for(mode, c), st, st ? NW'(5) : NW'(0), 1'b0);
      if (mode == 0) begin
        chk("ren_timing",   64'(ren_wb),    64'(c >= 1 && c <= n));
        chk("valid_timing", 64'(out_valid), 64'(c >= 3 && c <= n + 2));
        chk("done_timing",  64'(done),      64'(c == ((n == 0) ? 1 : n + 3)));
      end
      if (mode == 3) begin
        if (c <= 9 && ren_wb === 1'b1) reads_by_9++;
        if (n == 4) chk("stall_valid", 64'(out_valid), 64'(c >= 3 && c <= 13));
      end
      if (rst_after > 0 && (m_acc - acc0) == rst_after) begin
        cyc(1'b1, 1'b0, NW'(0), 1'b1);
        cyc(1'b1, 1'b0, NW'(0), 1'b0);
        return;
      end
      if (done === 1'b1) break;
    end
    chk("done_reached", 64'(done), 64'(1));
    if (mode == 3) chk("stall_reads", 64'(reads_by_9), 64'(2));
    chk("words_delivered", 64'(m_acc - acc0), 64'(n));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    num_words = '0;
    rdata_wb  = '0;
    for (int i = 0; i < int'(DEPTH); i++) bank[i] = DW'(i) + DW'(256);

    cyc(1'b0, 1'b0, NW'(0), 1'b1);
    cyc(1'b0, 1'b0, NW'(0), 1'b1);
    repeat (2) cyc(1'b1, 1'b0, NW'(0), 1'b0);

    run_drain(128, 0, 0, 0);
    run_drain(8, 1, 0, 0);
    run_drain(0, 0, 0, 0);
    run_drain(10, 0, 4, 0);
    repeat (4) cyc(1'b1, 1'b0, NW'(0), 1'b0);
    run_drain(5, 0, 0, 0);
    run_drain(10, 0, 0, 4);
    run_drain(3, 0, 0, 0);
    run_drain(4, 3, 0, 0);

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < int'(DEPTH); i++) bank[i] = {$urandom, $urandom};
      run_drain(int'($urandom_range(0, DEPTH)), 2, 0, 0);
    end
    repeat (3) cyc(1'b1, 1'b0, NW'(0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
